// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes the release of the board POR, stretches it,
// then releases NUM_STAGES active-low domain resets in order (bit 0 first).
// After every domain is out of reset, a software request or a watchdog
// timeout restarts the sequence. RST_CAUSE records which event caused it.
//
// Ports:
//   CLK         rising-edge clock
//   RST         asynchronous active-high reset (inverted POR)
//   SW_RST_REQ  software reset request, level-sampled each edge
//   WDT_EN      watchdog enable
//   WDT_KICK    watchdog service strobe
//   RST_OUT_N   active-low domain resets, bit 0 released first
//   READY       high once every domain is released
//   RST_CAUSE   00 power-on, 01 software, 10 watchdog

module reset_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 8,
  parameter int WDT_CYCLES     = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SW_RST_REQ,
  input  logic                  WDT_EN,
  input  logic                  WDT_KICK,
  output logic [NUM_STAGES-1:0] RST_OUT_N,
  output logic                  READY,
  output logic [1:0]            RST_CAUSE
);

  // One counter serves both the stretch and the inter-stage gap, since the
  // two phases never overlap. It is sized for the larger of the two.
  localparam int CNT_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    HOLD,
    STRETCH,
    RELEASE,
    RUN
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trigger_release;
  logic                   sw_trig;
  logic                   wdt_expire;
  logic [NUM_STAGES:0]    out_shift;
  logic [NUM_STAGES-1:0]  next_out;
  logic                   last_release;

  // Release synchronizer: cleared asynchronously, fills with ones after RST
  // drops, so assertion is immediate and release is clean.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign trigger_release = sync_q[SYNC_STAGES-1];

  // Software requests are ignored while still waiting for the POR release.
  assign sw_trig = SW_RST_REQ && (state != HOLD);

  // Next domain to release: shift a one in from the bottom. When the result
  // is all ones this release is the last one and READY goes with it.
  assign out_shift    = {RST_OUT_N, 1'b1};
  assign next_out     = out_shift[NUM_STAGES-1:0];
  assign last_release = &next_out;

  generate
    if (WDT_CYCLES > 0) begin : g_wdt
      localparam int WW = $clog2(WDT_CYCLES + 1);
      localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

      logic [WW-1:0] wdt_cnt;
      logic          counting;

      // A kick on the expiry edge suppresses expiry because it removes the
      // cycle from the count.
      assign counting   = (state == RUN) && WDT_EN && !WDT_KICK;
      assign wdt_expire = counting && (wdt_cnt == WDT_LAST);

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          wdt_cnt <= '0;
        end else if (!counting || wdt_expire) begin
          wdt_cnt <= '0;
        end else begin
          wdt_cnt <= wdt_cnt + WW'(1);
        end
      end
    end else begin : g_no_wdt
      logic unused_wdt_inputs;
      assign unused_wdt_inputs = WDT_EN ^ WDT_KICK;
      assign wdt_expire        = 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= HOLD;
      cnt       <= '0;
      RST_OUT_N <= '0;
      READY     <= 1'b0;
      RST_CAUSE <= CAUSE_POR;
    end else if (sw_trig || wdt_expire) begin
      // Internal restart: software takes priority over a coincident expiry.
      state     <= STRETCH;
      cnt       <= '0;
      RST_OUT_N <= '0;
      READY     <= 1'b0;
      RST_CAUSE <= sw_trig ? CAUSE_SW : CAUSE_WDT;
    end else begin
      case (state)
        HOLD: begin
          cnt <= '0;
          if (trigger_release) begin
            state <= STRETCH;
          end
        end
        STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            cnt       <= '0;
            RST_OUT_N <= next_out;
            if (last_release) begin
              READY <= 1'b1;
              state <= RUN;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == GAP_LAST) begin
            cnt       <= '0;
            RST_OUT_N <= next_out;
            if (last_release) begin
              READY <= 1'b1;
              state <= RUN;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          cnt <= '0;
        end
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer. Main instance uses default sequencing
// with a 64-cycle watchdog; a second instance has one stage, unit gap and no
// watchdog. Inputs change 2 time units after a rising edge, outputs are
// sampled at the same point.

module tb_reset_sequencer;

  logic       CLK;
  logic       RST;
  logic       SW_RST_REQ;
  logic       WDT_EN;
  logic       WDT_KICK;
  logic [2:0] rst_out_n;
  logic       ready;
  logic [1:0] rst_cause;
  logic [0:0] rst_out_n1;
  logic       ready1;
  logic [1:0] rst_cause1;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_STAGES(3), .SYNC_STAGES(2), .STRETCH_CYCLES(16),
    .STAGE_GAP(8), .WDT_CYCLES(64)
  ) dut (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .WDT_EN(WDT_EN),
    .WDT_KICK(WDT_KICK), .RST_OUT_N(rst_out_n), .READY(ready),
    .RST_CAUSE(rst_cause)
  );

  reset_sequencer #(
    .NUM_STAGES(1), .SYNC_STAGES(2), .STRETCH_CYCLES(16),
    .STAGE_GAP(1), .WDT_CYCLES(0)
  ) dut1 (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .WDT_EN(WDT_EN),
    .WDT_KICK(WDT_KICK), .RST_OUT_N(rst_out_n1), .READY(ready1),
    .RST_CAUSE(rst_cause1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: observed=still running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Called just after the trigger edge E; checks releases at E+16/24/32.
  task automatic run_seq(input string tag, input logic [1:0] cause, input bit chk1);
    for (int n = 1; n <= 32; n++) begin
      tick();
      if (n == 15) check({tag, "_e15"}, rst_out_n, 3'b000);
      if (n == 16) check({tag, "_e16"}, rst_out_n, 3'b001);
      if (n == 23) check({tag, "_e23"}, rst_out_n, 3'b001);
      if (n == 24) check({tag, "_e24"}, rst_out_n, 3'b011);
      if (n == 31) check({tag, "_e31"}, {ready, rst_out_n}, 4'b0011);
      if (n == 32) begin
        check({tag, "_e32"}, {ready, rst_out_n}, 4'b1111);
        check({tag, "_cause"}, rst_cause, cause);
      end
      if (chk1 && n == 15) check({tag, "_d1_e15"}, {ready1, rst_out_n1}, 2'b00);
      if (chk1 && n == 16) check({tag, "_d1_e16"}, {ready1, rst_out_n1}, 2'b11);
    end
  endtask

  task automatic por_start();
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
  endtask

  // Full POR: edges 0..2 spent in the synchronizer, then releases at 18/26/34.
  task automatic por(input string tag);
    por_start();
    tick();
    tick();
    check({tag, "_e1"}, {ready, rst_out_n}, 4'b0000);
    tick();
    run_seq(tag, 2'b00, 1'b1);
  endtask

  bit drop;
  bit drop1;

  initial begin
    RST        = 1'b1;
    SW_RST_REQ = 1'b0;
    WDT_EN     = 1'b0;
    WDT_KICK   = 1'b0;
    #1;
    check("reset_out", rst_out_n, 3'b000);
    check("reset_ready", ready, 1'b0);
    check("reset_cause", rst_cause, 2'b00);
    check("reset_d1", {ready1, rst_out_n1}, 2'b00);

    por("por");

    // RST asserted between edges during RELEASE
    por_start();
    repeat (23) tick();
    check("mid_release_out", rst_out_n, 3'b001);
    #3 RST = 1'b1;
    #1;
    check("async_rst_release", {ready, rst_out_n}, 4'b0000);
    por("por_after_release");

    // RST asserted between edges in RUN
    repeat (5) tick();
    #3 RST = 1'b1;
    #1;
    check("async_rst_run", {ready, rst_out_n}, 4'b0000);
    check("async_rst_run_cause", rst_cause, 2'b00);
    por("por_after_run");

    // One-cycle software request in RUN
    repeat (3) tick();
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    check("sw_assert", {ready, rst_out_n}, 4'b0000);
    check("sw_cause_now", rst_cause, 2'b01);
    run_seq("sw", 2'b01, 1'b1);

    // Second pulse during STRETCH restarts the count
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    repeat (5) tick();
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    check("sw2_assert", {ready, rst_out_n}, 4'b0000);
    run_seq("sw2", 2'b01, 1'b1);

    // Held request: outputs stay low, timing from the last high sample
    SW_RST_REQ = 1'b1;
    drop = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ({ready, rst_out_n} !== 4'b0000) drop = 1'b1;
    end
    check("held_low", drop, 1'b0);
    SW_RST_REQ = 1'b0;
    run_seq("held", 2'b01, 1'b1);

    // Watchdog, no kicks: expiry at R+64
    WDT_EN = 1'b1;
    repeat (63) tick();
    check("wdt_before", {ready, rst_out_n}, 4'b1111);
    tick();
    check("wdt_expire", {ready, rst_out_n}, 4'b0000);
    check("wdt_cause", rst_cause, 2'b10);
    check("wdt_d1_nowdt", {ready1, rst_cause1}, 3'b101);
    run_seq("wdt", 2'b10, 1'b0);

    // Kick on the expiry edge wins
    repeat (63) tick();
    WDT_KICK = 1'b1;
    tick();
    WDT_KICK = 1'b0;
    check("kick_on_expiry", {ready, rst_out_n}, 4'b1111);

    // Kick every 63 cycles for 1000 cycles
    drop  = 1'b0;
    drop1 = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      WDT_KICK = (i % 63 == 0);
      tick();
      if (ready !== 1'b1) drop = 1'b1;
      if (ready1 !== 1'b1) drop1 = 1'b1;
    end
    WDT_KICK = 1'b0;
    check("kick63_no_reset", drop, 1'b0);
    check("wdt0_d1_no_reset", drop1, 1'b0);
    check("kick63_cause", rst_cause, 2'b10);

    // Watchdog disabled
    WDT_EN = 1'b0;
    drop = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ready !== 1'b1) drop = 1'b1;
    end
    check("wdt_disabled", drop, 1'b0);

    // Software request on the expiry edge: software cause wins
    WDT_EN = 1'b1;
    repeat (63) tick();
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    WDT_EN     = 1'b0;
    check("coinc_out", {ready, rst_out_n}, 4'b0000);
    check("coinc_cause", rst_cause, 2'b01);
    check("coinc_d1_cause", rst_cause1, 2'b01);
    run_seq("coinc", 2'b01, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
